// File: rtl/cam_mjpeg_frame_feeder.sv
// Forwards whole camera frames into the MJPEG encoder. Each frame is preceded by an encoder
// reset pulse; 1-of-N decimation is supported, and frames that arrive while busy are dropped and counted.
module cam_mjpeg_frame_feeder #(
    parameter int unsigned PIX_W    = 24,
    parameter int unsigned H_ACT    = 1280,
    parameter int unsigned V_ACT    = 720,
    parameter int unsigned RST_CYC  = 8,
    parameter int unsigned SKIP_N   = 1,
    parameter int unsigned DONE_TMO = 2 ** 22,
    parameter int unsigned CNT_W    = 16,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic             i_cam_rgb888_pclk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_cam_vsync,
    input  logic             i_cam_de,
    input  logic [PIX_W-1:0] i_cam_data,
    input  logic             i_mjpeg_done,
    output logic             o_mjpeg_rst,
    output logic             o_mjpeg_de,
    output logic [PIX_W-1:0] o_mjpeg_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic [1:0]       o_err
);

    localparam int unsigned FRM_PIX = H_ACT * V_ACT;
    localparam int unsigned PIX_CW  = (FRM_PIX > 1) ? $clog2(FRM_PIX) : 1;
    localparam int unsigned TMO_CW  = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;
    localparam int unsigned RST_CW  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int unsigned SKIP_CW = (SKIP_N > 1) ? $clog2(SKIP_N) : 1;

    localparam logic [PIX_CW-1:0]  PIX_LAST  = PIX_CW'(FRM_PIX - 1);
    localparam logic [TMO_CW-1:0]  TMO_LAST  = TMO_CW'(DONE_TMO - 1);
    localparam logic [RST_CW-1:0]  RST_LOAD  = RST_CW'(RST_CYC - 1);
    localparam logic [SKIP_CW-1:0] SKIP_LAST = SKIP_CW'(SKIP_N - 1);

    typedef enum logic [1:0] {StWaitVs, StRst, StStream, StWaitDone} state_e;

    state_e              state_q;
    logic                vs_q, vs_prev_q, de_q;
    logic [PIX_W-1:0]    data_q;
    logic [PIX_CW-1:0]   pix_cnt_q;
    logic [TMO_CW-1:0]   tmo_cnt_q;
    logic [RST_CW-1:0]   rst_cnt_q;
    logic [SKIP_CW-1:0]  skip_q;
    logic                vs_edge;
    logic                tmo_hit;

    // Reset vsync history to the active level so a pin already active out of reset is not an edge.
    always_ff @(posedge i_cam_rgb888_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= VS_POL;
            vs_prev_q <= VS_POL;
            de_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            vs_q      <= i_cam_vsync;
            vs_prev_q <= vs_q;
            de_q      <= i_cam_de;
            data_q    <= i_cam_data;
        end
    end

    assign vs_edge = (vs_q == VS_POL) && (vs_prev_q != VS_POL);
    assign tmo_hit = (tmo_cnt_q == TMO_LAST) && !i_mjpeg_done;
    assign o_busy  = (state_q != StWaitVs);

    always_ff @(posedge i_cam_rgb888_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StWaitVs;
            pix_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            skip_q       <= '0;
            o_mjpeg_rst  <= 1'b0;
            o_mjpeg_de   <= 1'b0;
            o_mjpeg_data <= '0;
            o_frame_cnt  <= '0;
            o_drop_cnt   <= '0;
            o_err        <= '0;
        end else begin
            o_mjpeg_de   <= 1'b0;
            o_mjpeg_data <= '0;
            unique case (state_q)
                StWaitVs: begin
                    if (vs_edge && i_enable) begin
                        if (skip_q == '0) begin
                            state_q     <= StRst;
                            o_mjpeg_rst <= 1'b1;
                            rst_cnt_q   <= RST_LOAD;
                        end
                        skip_q <= (skip_q == SKIP_LAST) ? '0 : skip_q + SKIP_CW'(1);
                    end
                end
                StRst: begin
                    if (de_q) o_err[0] <= 1'b1;
                    if (rst_cnt_q == '0) begin
                        state_q     <= StStream;
                        o_mjpeg_rst <= 1'b0;
                        pix_cnt_q   <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RST_CW'(1);
                    end
                end
                StStream: begin
                    // Last pixel beats a coincident vsync: the frame completes normally.
                    if (de_q && pix_cnt_q == PIX_LAST) begin
                        o_mjpeg_de   <= 1'b1;
                        o_mjpeg_data <= data_q;
                        pix_cnt_q    <= '0;
                        tmo_cnt_q    <= '0;
                        state_q      <= StWaitDone;
                    end else if (vs_edge) begin
                        o_err[0]    <= 1'b1;
                        o_drop_cnt  <= o_drop_cnt + CNT_W'(1);
                        o_mjpeg_rst <= 1'b1;
                        rst_cnt_q   <= RST_LOAD;
                        state_q     <= StRst;
                    end else if (de_q) begin
                        o_mjpeg_de   <= 1'b1;
                        o_mjpeg_data <= data_q;
                        pix_cnt_q    <= pix_cnt_q + PIX_CW'(1);
                    end
                end
                StWaitDone: begin
                    tmo_cnt_q  <= tmo_cnt_q + TMO_CW'(1);
                    o_drop_cnt <= o_drop_cnt + CNT_W'(vs_edge) + CNT_W'(tmo_hit);
                    if (i_mjpeg_done) begin
                        o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                        state_q     <= StWaitVs;
                    end else if (tmo_hit) begin
                        o_err[1] <= 1'b1;
                        state_q  <= StWaitVs;
                    end
                end
                default: state_q <= StWaitVs;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_mjpeg_frame_feeder.sv
// Directed bench: 4x2 frames, one instance forwarding every frame and one decimating 1-of-3.
module tb_cam_mjpeg_frame_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic        vsync = 1'b0;
    logic        de = 1'b0;
    logic [23:0] data = '0;
    logic        done = 1'b0;

    logic        mrst, mde, busy;
    logic [23:0] mdata;
    logic [15:0] frame_cnt, drop_cnt;
    logic [1:0]  err;

    logic        mrst2, mde2, busy2;
    logic [23:0] mdata2;
    logic [15:0] frame_cnt2, drop_cnt2;
    logic [1:0]  err2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cam_mjpeg_frame_feeder #(
        .PIX_W(24), .H_ACT(4), .V_ACT(2), .RST_CYC(8), .SKIP_N(1), .DONE_TMO(100), .CNT_W(16),
        .VS_POL(1'b1)
    ) u_dut (
        .i_cam_rgb888_pclk(clk), .rst_n(rst_n), .i_enable(enable), .i_cam_vsync(vsync),
        .i_cam_de(de), .i_cam_data(data), .i_mjpeg_done(done), .o_mjpeg_rst(mrst),
        .o_mjpeg_de(mde), .o_mjpeg_data(mdata), .o_busy(busy), .o_frame_cnt(frame_cnt),
        .o_drop_cnt(drop_cnt), .o_err(err)
    );

    cam_mjpeg_frame_feeder #(
        .PIX_W(24), .H_ACT(4), .V_ACT(2), .RST_CYC(8), .SKIP_N(3), .DONE_TMO(100), .CNT_W(16),
        .VS_POL(1'b1)
    ) u_dec (
        .i_cam_rgb888_pclk(clk), .rst_n(rst_n), .i_enable(enable), .i_cam_vsync(vsync),
        .i_cam_de(de), .i_cam_data(data), .i_mjpeg_done(done), .o_mjpeg_rst(mrst2),
        .o_mjpeg_de(mde2), .o_mjpeg_data(mdata2), .o_busy(busy2), .o_frame_cnt(frame_cnt2),
        .o_drop_cnt(drop_cnt2), .o_err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        vsync = 1'b0; de = 1'b0; data = '0; done = 1'b0; enable = 1'b1;
        #2 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One-cycle vsync, then count encoder-reset cycles on both instances.
    task automatic pulse_vs(output int r1, output int r2);
        r1 = 0; r2 = 0;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            r1 += int'(mrst);
            r2 += int'(mrst2);
        end
    endtask

    task automatic stream_pix(input int n, input logic [23:0] base, output int d1, output int d2);
        d1 = 0; d2 = 0;
        for (int i = 0; i < n + 2; i++) begin
            de   = (i < n);
            data = (i < n) ? base + 24'(i) : 24'h0;
            tick();
            d1 += int'(mde);
            d2 += int'(mde2);
        end
        de = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({mrst, mde, mdata, busy} !== 27'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rst=%b de=%b data=%h busy=%b, want all 0",
                     mrst, mde, mdata, busy);
        end
        n_cmp++;
        if ({frame_cnt, drop_cnt, err} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_counts: got frame=%0d drop=%0d err=%b, want 0/0/00",
                     frame_cnt, drop_cnt, err);
        end
    endtask

    task automatic test_basic_frame();
        int r1, r2;
        do_reset();
        pulse_vs(r1, r2);
        n_cmp++;
        if (r1 !== 8) begin
            n_fail++; $display("FAIL t1_rst_len: got %0d cycles, want 8", r1);
        end
        for (int i = 0; i <= 8; i++) begin
            de   = (i < 8);
            data = (i < 8) ? 24'(i + 1) : 24'h0;
            tick();
            n_cmp++;
            if (i == 0) begin
                if (mde !== 1'b0) begin
                    n_fail++; $display("FAIL t1_lag_early: got de=%b, want 0", mde);
                end
            end else if (mde !== 1'b1 || mdata !== 24'(i)) begin
                n_fail++;
                $display("FAIL t1_pixel%0d: got de=%b data=%h, want de=1 data=%h", i, mde, mdata,
                         24'(i));
            end
        end
        tick();
        n_cmp++;
        if (mde !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL t1_wait_done: got de=%b busy=%b, want 0/1", mde, busy);
        end
        pulse_done();
        n_cmp++;
        if (frame_cnt !== 16'd1 || err !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_done: got frame=%0d err=%b busy=%b, want 1/00/0",
                     frame_cnt, err, busy);
        end
    endtask

    task automatic test_decimation();
        int r1, r2, d1, d2, want;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            pulse_vs(r1, r2);
            stream_pix(8, 24'h100 * 24'(f + 1), d1, d2);
            pulse_done();
            want = (f == 0 || f == 3) ? 8 : 0;
            n_cmp++;
            if (r2 !== want || d2 !== want) begin
                n_fail++;
                $display("FAIL t2_frame%0d: got rst=%0d px=%0d, want rst=%0d px=%0d",
                         f, r2, d2, want, want);
            end
        end
        n_cmp++;
        if (frame_cnt2 !== 16'd2 || drop_cnt2 !== 16'd0) begin
            n_fail++;
            $display("FAIL t2_counts: got frame=%0d drop=%0d, want 2/0", frame_cnt2, drop_cnt2);
        end
        n_cmp++;
        if (frame_cnt !== 16'd6) begin
            n_fail++; $display("FAIL t2_nodecim_frames: got %0d, want 6", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int r1, r2, d1, d2;
        do_reset();
        pulse_vs(r1, r2);
        stream_pix(8, 24'h10, d1, d2);
        for (int k = 0; k < 2; k++) begin
            vsync = 1'b1; tick(); vsync = 1'b0; tick(); tick();
        end
        n_cmp++;
        if (drop_cnt !== 16'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL t3_drops: got drop=%0d busy=%b, want 2/1", drop_cnt, busy);
        end
        pulse_done();
        n_cmp++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t3_done: got frame=%0d busy=%b, want 1/0", frame_cnt, busy);
        end
        pulse_vs(r1, r2);
        n_cmp++;
        if (r1 !== 8) begin
            n_fail++; $display("FAIL t3_next_accept: got rst=%0d cycles, want 8", r1);
        end
    endtask

    task automatic test_short_frame();
        int r1, r2, d1, d2;
        do_reset();
        pulse_vs(r1, r2);
        stream_pix(5, 24'h20, d1, d2);
        pulse_vs(r1, r2);
        n_cmp++;
        if (r1 !== 8 || err !== 2'b01 || drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL t4_short: got rst=%0d err=%b drop=%0d, want 8/01/1", r1, err, drop_cnt);
        end
        stream_pix(8, 24'h30, d1, d2);
        n_cmp++;
        if (d1 !== 8) begin
            n_fail++; $display("FAIL t4_refill: got %0d pixels, want 8", d1);
        end
        pulse_done();
        n_cmp++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t4_done: got frame=%0d busy=%b, want 1/0", frame_cnt, busy);
        end
    endtask

    task automatic test_timeout();
        int r1, r2, d1, d2;
        do_reset();
        pulse_vs(r1, r2);
        stream_pix(8, 24'h40, d1, d2);
        repeat (98) tick();
        n_cmp++;
        if (busy !== 1'b1 || err !== 2'b00) begin
            n_fail++; $display("FAIL t5_before: got busy=%b err=%b, want 1/00", busy, err);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || err !== 2'b10 || drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL t5_timeout: got busy=%b err=%b drop=%0d, want 0/10/1",
                     busy, err, drop_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int r1, r2, d1, d2;
        do_reset();
        pulse_vs(r1, r2);
        for (int i = 0; i < 4; i++) begin
            de = 1'b1; data = 24'h50 + 24'(i); tick();
        end
        data = 24'h54;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mde !== 1'b0 || busy !== 1'b0 || mrst !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_async: got de=%b busy=%b rst=%b, want 0/0/0", mde, busy, mrst);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        de = 1'b0;
        tick();
        n_cmp++;
        if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0 || err !== 2'b00) begin
            n_fail++;
            $display("FAIL t6_cleared: got frame=%0d drop=%0d err=%b, want 0/0/00",
                     frame_cnt, drop_cnt, err);
        end
        stream_pix(8, 24'h60, d1, d2);
        n_cmp++;
        if (d1 !== 0) begin
            n_fail++; $display("FAIL t6_no_forward: got %0d pixels, want 0", d1);
        end
        pulse_vs(r1, r2);
        n_cmp++;
        if (r1 !== 8) begin
            n_fail++; $display("FAIL t6_fresh_vs: got rst=%0d cycles, want 8", r1);
        end
    endtask

    task automatic test_enable();
        int r1, r2;
        do_reset();
        enable = 1'b0;
        pulse_vs(r1, r2);
        n_cmp++;
        if (r1 !== 0 || busy !== 1'b0 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL en_off: got rst=%0d busy=%b drop=%0d, want 0/0/0", r1, busy, drop_cnt);
        end
        enable = 1'b1;
        pulse_vs(r1, r2);
        n_cmp++;
        if (r2 !== 8) begin
            n_fail++; $display("FAIL en_skip_kept: got dec rst=%0d, want 8", r2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_decimation();
        test_back_to_back();
        test_short_frame();
        test_timeout();
        test_reset_midframe();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
